// File: rtl/if_fetch.sv
// Instruction fetch: holds the PC, reads four bytes over a byte-wide synchronous port, presents a little-endian word.
// Latency: inst_valid_o rises 5 cycles after entering F0 with the port free; each busy cycle in F0..F3 adds one.
// Backpressure: stall_i holds the presented word and suppresses requests; mem_busy_i pauses issue; branch_i redirects.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          MEM_AW   = 17
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_i,
  input  logic [31:0]       branch_target_i,
  input  logic              mem_busy_i,
  input  logic [7:0]        mem_data_i,
  output logic              mem_req_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       pc_o,
  output logic [31:0]       inst_o,
  output logic              inst_valid_o
);

  // F0..F3 are encoded 0..3 so the low two bits are the byte offset being issued.
  localparam logic [2:0] ST_F0   = 3'd0;
  localparam logic [2:0] ST_F1   = 3'd1;
  localparam logic [2:0] ST_F2   = 3'd2;
  localparam logic [2:0] ST_F3   = 3'd3;
  localparam logic [2:0] ST_LAST = 3'd4;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic [2:0]  state;
  logic [31:0] pc;
  logic        pending;     // a read was issued last cycle; its byte is on mem_data_i now
  logic [1:0]  idx;         // byte lane of the pending read
  logic [23:0] asm_q;       // bytes 0..2; byte 3 is merged straight into inst_q
  logic [31:0] inst_q;
  logic        valid_q;

  logic        issue_state;
  logic [1:0]  byte_k;
  logic        req;

  assign issue_state = (state == ST_F0) || (state == ST_F1) ||
                       (state == ST_F2) || (state == ST_F3);
  assign byte_k      = state[1:0];

  // A request issues in F0..F3 unless the port is lent out, a redirect is taking effect, or reset is held.
  assign req = issue_state && !mem_busy_i && !branch_i && !rst;

  assign mem_req_o    = req;
  assign mem_addr_o   = req ? (pc[MEM_AW-1:0] + MEM_AW'(byte_k)) : '0;
  assign pc_o         = pc;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;

  // Sequencing: reset, then redirect, then capture/issue and hand-off to decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_F0;
      pc      <= RESET_PC;
      pending <= 1'b0;
      idx     <= 2'd0;
      asm_q   <= 24'd0;
      inst_q  <= 32'd0;
      valid_q <= 1'b0;
    end else if (branch_i) begin
      // The byte returning next cycle belongs to the old path; clearing pending drops it.
      state   <= ST_F0;
      pc      <= branch_target_i;
      pending <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      pending <= req;
      if (req) begin
        idx <= byte_k;
      end

      if (pending) begin
        case (idx)
          2'd0:    asm_q[7:0]   <= mem_data_i;
          2'd1:    asm_q[15:8]  <= mem_data_i;
          2'd2:    asm_q[23:16] <= mem_data_i;
          default: ;
        endcase
      end

      case (state)
        ST_F0, ST_F1, ST_F2, ST_F3: begin
          if (req) begin
            state <= state + 3'd1;
          end
        end
        ST_LAST: begin
          if (pending && (idx == 2'd3)) begin
            inst_q  <= {mem_data_i, asm_q};
            valid_q <= 1'b1;
            state   <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (!stall_i) begin
            pc      <= pc + 32'd4;
            valid_q <= 1'b0;
            state   <= ST_F0;
          end
        end
        default: state <= ST_F0;
      endcase
    end
  end

endmodule
